mem_arbiter: RTL and testbench

Shares one single-ported 16-bit unified memory between the instruction-fetch port and the data (memory-stage) port of the 16-bit pipelined processor. Each request is a fixed-latency memory transaction. The block grants the memory to one requester at a time, returns read data with a one-cycle acknowledge pulse, and drives a combinational `stall` so the pipeline freezes while any access is pending. Data accesses have priority. A starvation counter guarantees that instruction fetch makes forward progress.

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose: single-port 16-bit memory shared by instruction fetch and data ports; data has priority,
//          a starvation counter forces a fetch grant after STARVE_MAX data grants past a waiting fetch.
// Latency: grant edge -> mem_en for MEM_LAT cycles -> one-cycle ack; next grant may issue in the ack cycle.
// Backpressure: requesters hold req until ack; stall = pending request not yet acked (combinational).
// Ports: clk/rst (async active-high); if_req/if_addr -> if_rdata/if_ack; d_req/d_we/d_addr/d_wdata
//        -> d_rdata/d_ack; stall; mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory.
module mem_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam int STV_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);
   localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state_q, state_d;
   logic              gnt_q, gnt_d;            // 0 = fetch owns memory, 1 = data
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [STV_W-1:0]  starve_q, starve_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              if_ack_q, if_ack_d;
   logic              d_ack_q, d_ack_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic if_elig;
   logic d_elig;

   // A request still held high during its own ack cycle is already served.
   assign if_elig = if_req & ~if_ack_q;
   assign d_elig  = d_req  & ~d_ack_q;

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      cnt_d       = cnt_q;
      starve_d    = starve_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_ack_d    = 1'b0;
      d_ack_d     = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;

      case (state_q)
         IDLE: begin
            if (d_elig && (!if_elig || (starve_q != STV_MAX))) begin
               gnt_d       = 1'b1;
               mem_en_d    = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               cnt_d       = CNT_ONE;
               state_d     = BUSY;
               // Data only wins over a waiting fetch below STV_MAX, so this never overflows.
               if (if_elig) starve_d = starve_q + STV_ONE;
            end else if (if_elig) begin
               gnt_d       = 1'b0;
               mem_en_d    = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
               cnt_d       = CNT_ONE;
               starve_d    = '0;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == LAST_CNT) begin
               if (gnt_q) begin
                  d_rdata_d = mem_rdata;
                  d_ack_d   = 1'b1;
               end else begin
                  if_rdata_d = mem_rdata;
                  if_ack_d   = 1'b1;
               end
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               cnt_d    = '0;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= 1'b0;
         cnt_q       <= '0;
         starve_q    <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         cnt_q       <= cnt_d;
         starve_q    <= starve_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         d_ack_q     <= d_ack_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign stall     = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_ack    = if_ack_q;
   assign d_ack     = d_ack_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed bench for mem_arbiter with a small behavioural memory behind it.
// Latency: cycle-exact checks of grant, mem_en window and ack pulse (MEM_LAT=2, STARVE_MAX=4).
// Backpressure: requests held until ack; stall checked against the pending-request rule.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [15:0] if_addr;
   logic [15:0] if_rdata;
   logic        if_ack;
   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic [15:0] d_rdata;
   logic        d_ack;
   logic        stall;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   int total = 0;
   int bad   = 0;

   logic [15:0] mem [0:255];

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack), .stall(stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write on the clock edge while enabled.
   assign mem_rdata = mem[mem_addr[7:0]];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
         mem[8'h40] <= 16'hABCD;
         mem[8'h10] <= 16'h1111;
      end else if (mem_en && mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one cycle; inputs are driven 2 time units after the edge, checks 1 later.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0;
      step(); step(); settle();
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_acks", {if_ack, d_ack}, 0);
      chk("rst_rdata", {if_rdata, d_rdata}, 0);
      chk("rst_stall", stall, 0);
      rst = 1'b0;
      step();

      // Fetch alone, request held through its ack cycle.
      if_req = 1'b1; if_addr = 16'h0040; settle();
      chk("t1_c0_stall", stall, 1);
      chk("t1_c0_mem_en", mem_en, 0);
      step(); settle();
      chk("t1_c1_mem_en", mem_en, 1);
      chk("t1_c1_mem_addr", mem_addr, 16'h0040);
      chk("t1_c1_stall", stall, 1);
      step(); settle();
      chk("t1_c2_mem_en", mem_en, 1);
      chk("t1_c2_if_ack", if_ack, 0);
      step(); settle();
      chk("t1_c3_if_ack", if_ack, 1);
      chk("t1_c3_if_rdata", if_rdata, 16'hABCD);
      chk("t1_c3_stall", stall, 0);
      chk("t1_c3_mem_en", mem_en, 0);
      step(); if_req = 1'b0; settle();
      chk("t1_c4_no_regrant", mem_en, 0);
      chk("t1_c4_if_ack", if_ack, 0);

      // Both request together: data first, fetch granted in the data ack cycle.
      step();
      if_req = 1'b1; if_addr = 16'h0040; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
      step(); settle();
      chk("t2_c1_mem_addr", mem_addr, 16'h0010);
      chk("t2_c1_starve", dut.starve_q, 1);
      step(); step(); settle();
      chk("t2_c3_d_ack", d_ack, 1);
      chk("t2_c3_d_rdata", d_rdata, 16'h1111);
      chk("t2_c3_if_ack", if_ack, 0);
      chk("t2_c3_stall", stall, 1);
      step(); d_req = 1'b0; settle();
      chk("t2_c4_mem_en", mem_en, 1);
      chk("t2_c4_mem_addr", mem_addr, 16'h0040);
      chk("t2_c4_starve", dut.starve_q, 0);
      step(); step(); settle();
      chk("t2_c6_if_ack", if_ack, 1);
      chk("t2_c6_if_rdata", if_rdata, 16'hABCD);
      chk("t2_c6_d_ack", d_ack, 0);
      step(); if_req = 1'b0;

      // Data write then data read of the same address.
      step();
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h5A5A;
      step(); settle();
      chk("t3_c1_mem_we", mem_we, 1);
      chk("t3_c1_mem_wdata", mem_wdata, 16'h5A5A);
      step(); settle();
      chk("t3_c2_mem_we", mem_we, 1);
      step(); settle();
      chk("t3_c3_d_ack", d_ack, 1);
      chk("t3_c3_mem_we", mem_we, 0);
      step(); d_we = 1'b0; settle();
      step(); settle();
      chk("t3_c5_mem_we", mem_we, 0);
      chk("t3_c5_mem_addr", mem_addr, 16'h0020);
      step(); step(); settle();
      chk("t3_c7_d_ack", d_ack, 1);
      chk("t3_c7_d_rdata", d_rdata, 16'h5A5A);
      step(); d_req = 1'b0;

      // Starvation: fetch waits behind 4 data grants. Fetch steps aside in each data ack
      // cycle, where it would otherwise be the only eligible requester and win early.
      step();
      d_addr = 16'h0010; d_we = 1'b0; if_addr = 16'h0040;
      for (int r = 0; r < 4; r++) begin
         if_req = 1'b1; d_req = 1'b1;
         step(); settle();
         chk("t4_data_grant", mem_addr, 16'h0010);
         chk("t4_starve", dut.starve_q, r + 1);
         step(); step(); if_req = 1'b0; settle();
         chk("t4_d_ack", d_ack, 1);
         step();
      end
      if_req = 1'b1; d_req = 1'b1;
      step(); settle();
      chk("t4_fetch_wins", mem_addr, 16'h0040);
      chk("t4_starve_clr", dut.starve_q, 0);
      step(); step(); settle();
      chk("t4_if_ack", if_ack, 1);
      chk("t4_if_ack_excl", d_ack, 0);
      step(); if_req = 1'b0; settle();
      chk("t4_data_after", mem_addr, 16'h0010);
      chk("t4_starve_hold", dut.starve_q, 0);
      step(); step(); settle();
      chk("t4_last_d_ack", d_ack, 1);
      chk("t4_last_d_rdata", d_rdata, 16'h1111);
      step(); d_req = 1'b0;

      // Asynchronous reset in the first BUSY cycle of a write.
      step();
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'h7777;
      step(); settle();
      chk("t5_busy_mem_we", mem_we, 1);
      rst = 1'b1; #1;
      chk("t5_async_mem_en", mem_en, 0);
      chk("t5_async_mem_we", mem_we, 0);
      chk("t5_async_mem_addr", mem_addr, 0);
      step(); settle();
      chk("t5_no_ack_a", d_ack, 0);
      step(); settle();
      chk("t5_no_ack_b", d_ack, 0);
      rst = 1'b0;
      step(); settle();
      chk("t5_regrant_mem_en", mem_en, 1);
      chk("t5_regrant_mem_we", mem_we, 1);
      chk("t5_regrant_d_ack", d_ack, 0);
      step(); step(); settle();
      chk("t5_d_ack", d_ack, 1);
      chk("t5_mem_written", mem[8'h30], 16'h7777);
      step(); d_req = 1'b0; settle();
      chk("t5_single_ack", d_ack, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
